// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 YUV422 luma capture into a frame-buffer write port, with frame count and geometry error flag
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int AW = 20
) (
  input  logic          PCLK,
  input  logic          reset,
  input  logic          cap_en,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    D,
  output logic          we,
  output logic [AW-1:0] addra,
  output logic [3:0]    vga_o,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          line_err
);
  localparam int CW = $clog2(H_ACTIVE + 2);
  localparam int LW = $clog2(V_ACTIVE + 2);
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE + 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(V_ACTIVE + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FRAME, S_DONE} state_t;
  state_t state, state_nx;
  logic vs_q, vs_q_d, hr_q, hr_q_d, byte_ph;
  logic [7:0] d_q;
  logic [3:0] unused_lo;
  logic [CW-1:0] col;
  logic [LW-1:0] line, line_nx;
  logic [AW-1:0] line_base;
  logic vs_fall, vs_rise, hr_fall, wr, start, fin;
  assign unused_lo = d_q[3:0];
  assign vs_fall = vs_q_d & ~vs_q;
  assign vs_rise = ~vs_q_d & vs_q;
  assign hr_fall = hr_q_d & ~hr_q;
  assign wr = state == S_FRAME && hr_q && !byte_ph && col < CW'(H_ACTIVE) && line < LW'(V_ACTIVE);
  assign line_nx = (hr_fall && line != LINE_MAX) ? line + 1'b1 : line;
  assign start = state == S_WAIT && state_nx == S_FRAME;
  assign fin = state == S_FRAME && vs_rise;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = cap_en ? S_WAIT : S_IDLE;
      S_WAIT:  state_nx = !cap_en ? S_IDLE : (vs_fall ? S_FRAME : S_WAIT);
      S_FRAME: state_nx = vs_rise ? S_DONE : S_FRAME;
      S_DONE:  state_nx = cap_en ? S_WAIT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state <= S_IDLE;
      {vs_q, vs_q_d, hr_q, hr_q_d} <= '0;
      d_q <= '0;
      byte_ph <= 1'b0;
      col <= '0;
      line <= '0;
      line_base <= '0;
      we <= 1'b0;
      addra <= '0;
      vga_o <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      vs_q <= VSYNC;
      vs_q_d <= vs_q;
      hr_q <= HREF;
      hr_q_d <= hr_q;
      d_q <= D;
      state <= state_nx;
      we <= wr;
      if (wr) begin
        addra <= line_base + AW'(col);
        vga_o <= d_q[7:4];
      end
      frame_done <= fin;
      if (fin) frame_cnt <= frame_cnt + 1'b1;
      if (start) begin
        byte_ph <= 1'b0;
        col <= '0;
        line <= '0;
        line_base <= '0;
      end else if (state == S_FRAME) begin
        if (hr_q) begin
          byte_ph <= ~byte_ph;
          if (!byte_ph && col != COL_MAX) col <= col + 1'b1;
        end
        // hr_fall implies hr_q=0, so this never collides with the pixel update above
        if (hr_fall) begin
          byte_ph <= 1'b0;
          col <= '0;
          line <= line_nx;
          line_base <= line_base + AW'(H_ACTIVE);
          if (col != CW'(H_ACTIVE)) line_err <= 1'b1;
        end
        if (vs_rise && line_nx != LW'(V_ACTIVE)) line_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed capture scenarios on a full-size and a tiny (4x2) instance, checked every cycle against a pixel-level model
module tb_ov7670_capture;
  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  logic rst_a = 1'b1, rst_b = 1'b1, cen_a = 1'b0, cen_b = 1'b0, VSYNC = 1'b0, HREF = 1'b0;
  logic [7:0] D = 8'h00;
  logic we_a, we_b, fd_a, fd_b, le_a, le_b;
  logic [19:0] addra_a, addra_b;
  logic [3:0] vga_a, vga_b;
  logic [7:0] fc_a, fc_b;
  ov7670_capture u_a (.PCLK(PCLK), .reset(rst_a), .cap_en(cen_a), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .we(we_a), .addra(addra_a), .vga_o(vga_a), .frame_done(fd_a), .frame_cnt(fc_a), .line_err(le_a));
  ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .AW(20)) u_b (.PCLK(PCLK), .reset(rst_b), .cap_en(cen_b),
    .VSYNC(VSYNC), .HREF(HREF), .D(D), .we(we_b), .addra(addra_b), .vga_o(vga_b), .frame_done(fd_b),
    .frame_cnt(fc_b), .line_err(le_b));
  localparam int INF = 32'h7fffffff;
  typedef struct {int c; int a; logic [3:0] v;} wr_t;
  wr_t qw0[$], qw1[$];
  int qd0[$], qd1[$];
  int hh[2] = '{640, 4};
  int vv[2] = '{480, 2};
  int in_frame[2], m_line[2], err_from[2], mcnt[2], nwe[2], ndone[2];
  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic cmp(input int d, input logic we, input logic [19:0] ad, input logic [3:0] v,
                     input logic fd, input logic [7:0] fc, input logic le);
    wr_t w;
    logic ew, ed;
    ew = 1'b0;
    ed = 1'b0;
    if (d == 0) begin
      if (qw0.size() > 0 && qw0[0].c == cyc) begin ew = 1'b1; w = qw0.pop_front(); end
      if (qd0.size() > 0 && qd0[0] == cyc) begin ed = 1'b1; qd0.delete(0); end
    end else begin
      if (qw1.size() > 0 && qw1[0].c == cyc) begin ew = 1'b1; w = qw1.pop_front(); end
      if (qd1.size() > 0 && qd1[0] == cyc) begin ed = 1'b1; qd1.delete(0); end
    end
    chk($sformatf("we[%0d]", d), 32'(we), 32'(ew));
    if (ew) begin
      chk($sformatf("addra[%0d]", d), 32'(ad), 32'(w.a));
      chk($sformatf("vga_o[%0d]", d), 32'(v), 32'(w.v));
    end
    if (we) nwe[d]++;
    if (fd) ndone[d]++;
    if (ed) mcnt[d] = (mcnt[d] + 1) % 256;
    chk($sformatf("frame_done[%0d]", d), 32'(fd), 32'(ed));
    chk($sformatf("frame_cnt[%0d]", d), 32'(fc), 32'(mcnt[d]));
    chk($sformatf("line_err[%0d]", d), 32'(le), 32'(cyc >= err_from[d]));
  endtask
  initial forever begin
    @(posedge PCLK);
    #2;
    cmp(0, we_a, addra_a, vga_a, fd_a, fc_a, le_a);
    cmp(1, we_b, addra_b, vga_b, fd_b, fc_b, le_b);
  end
  function automatic logic cen(input int d);
    return d == 0 ? cen_a : cen_b;
  endfunction
  task automatic set_cen(input int t, input logic v);
    if (t == 0) cen_a = v; else cen_b = v;
  endtask
  task automatic set_rst(input int t, input logic v);
    if (t == 0) rst_a = v; else rst_b = v;
  endtask
  task automatic model_reset(input int d);
    if (d == 0) begin qw0.delete(); qd0.delete(); end else begin qw1.delete(); qd1.delete(); end
    in_frame[d] = 0;
    m_line[d] = 0;
    mcnt[d] = 0;
    err_from[d] = INF;
  endtask
  task automatic set_err(input int d);
    if (cyc + 2 < err_from[d]) err_from[d] = cyc + 2;
  endtask
  // a byte launched after edge k is captured at k+1 and written at k+2
  task automatic push_pix(input int p, input logic [7:0] y);
    wr_t w;
    for (int d = 0; d < 2; d++)
      if (in_frame[d] != 0 && p < hh[d] && m_line[d] < vv[d]) begin
        w.c = cyc + 2;
        w.a = m_line[d] * hh[d] + p;
        w.v = y[7:4];
        if (d == 0) qw0.push_back(w); else qw1.push_back(w);
      end
  endtask
  task automatic line_end_model(input int npix);
    for (int d = 0; d < 2; d++)
      if (in_frame[d] != 0) begin
        if (npix != hh[d]) set_err(d);
        m_line[d]++;
      end
  endtask
  task automatic frame_end_model();
    for (int d = 0; d < 2; d++)
      if (in_frame[d] != 0) begin
        if (d == 0) qd0.push_back(cyc + 2); else qd1.push_back(cyc + 2);
        if (m_line[d] != vv[d]) set_err(d);
        in_frame[d] = 0;
      end
  endtask
  task automatic vsync_pulse();
    @(negedge PCLK);
    if (!VSYNC) begin
      VSYNC = 1'b1;
      frame_end_model();
    end
    repeat (3) @(negedge PCLK);
    @(negedge PCLK);
    VSYNC = 1'b0;
    for (int d = 0; d < 2; d++)
      if (cen(d)) begin
        in_frame[d] = 1;
        m_line[d] = 0;
      end
    repeat (4) @(negedge PCLK);
  endtask
  task automatic line_t(input int t, input int npix, input logic [7:0] yfirst, input logic [7:0] ybase,
                        input int cen_at, input int rst_at, input bit end_vs, input bit lat);
    logic [7:0] y;
    for (int p = 0; p < npix; p++) begin
      y = (p == 0) ? yfirst : (ybase | {4'h0, 4'(p)});
      @(negedge PCLK);
      if (p == cen_at) set_cen(t, 1'b1);
      if (rst_at >= 0 && p == rst_at) begin set_rst(t, 1'b1); model_reset(t); end
      if (rst_at >= 0 && p == rst_at + 1) set_rst(t, 1'b0);
      HREF = 1'b1;
      D = y;
      push_pix(p, y);
      if (lat && p == 1) begin
        chk("lat_we", 32'(t == 0 ? we_a : we_b), 32'd1);
        chk("lat_vga", 32'(t == 0 ? vga_a : vga_b), 32'hF);
        chk("lat_addr", 32'(t == 0 ? addra_a : addra_b), 32'd0);
      end
      @(negedge PCLK);
      D = 8'h5C;
      if (lat && p == 1) chk("chroma_no_we", 32'(t == 0 ? we_a : we_b), 32'd0);
      if (rst_at >= 0 && p == rst_at) begin
        chk("rst_we", 32'(t == 0 ? we_a : we_b), 32'd0);
        chk("rst_addra", 32'(t == 0 ? addra_a : addra_b), 32'd0);
        chk("rst_frame_cnt", 32'(t == 0 ? fc_a : fc_b), 32'd0);
      end
    end
    @(negedge PCLK);
    HREF = 1'b0;
    D = 8'h00;
    line_end_model(npix);
    if (end_vs) begin
      VSYNC = 1'b1;
      frame_end_model();
    end
    repeat (3) @(negedge PCLK);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
  initial begin
    for (int d = 0; d < 2; d++) err_from[d] = INF;
    repeat (4) @(negedge PCLK);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge PCLK);
    chk("reset_we", 32'(we_a), 32'd0);
    chk("reset_addra", 32'(addra_a), 32'd0);
    chk("reset_vga_o", 32'(vga_a), 32'd0);
    chk("reset_frame_done", 32'(fd_a), 32'd0);
    chk("reset_frame_cnt", 32'(fc_a), 32'd0);
    chk("reset_line_err", 32'(le_a), 32'd0);
    chk("reset_we_b", 32'(we_b), 32'd0);
    cen_a = 1'b1;
    vsync_pulse();
    line_t(0, 650, 8'hF3, 8'h60, -1, -1, 1'b0, 1'b1);
    chk("long_line_err", 32'(le_a), 32'd1);
    line_t(0, 16, 8'hA0, 8'hA0, -1, -1, 1'b0, 1'b0);
    cen_a = 1'b0;
    vsync_pulse();
    chk("a_frame_cnt1", 32'(fc_a), 32'd1);
    chk("a_writes_first_frame", 32'(nwe[0]), 32'd656);
    line_t(0, 30, 8'hB0, 8'hB0, 10, -1, 1'b0, 1'b0);
    line_t(0, 20, 8'hB0, 8'hB0, -1, -1, 1'b0, 1'b0);
    chk("midframe_no_writes", 32'(nwe[0]), 32'd656);
    vsync_pulse();
    for (int l = 0; l < 100; l++) line_t(0, 40, 8'hC5, 8'hC0, -1, -1, 1'b0, 1'b0);
    line_t(0, 40, 8'hD5, 8'hD0, -1, 37, 1'b0, 1'b0);
    vsync_pulse();
    line_t(0, 24, 8'hE0, 8'hE0, -1, -1, 1'b0, 1'b0);
    line_t(0, 24, 8'hE0, 8'hE0, -1, -1, 1'b0, 1'b0);
    cen_a = 1'b0;
    vsync_pulse();
    chk("a_frame_cnt_after_reset", 32'(fc_a), 32'd1);
    cen_b = 1'b1;
    vsync_pulse();
    line_t(1, 4, 8'hA0, 8'hA0, -1, -1, 1'b0, 1'b0);
    line_t(1, 4, 8'hA0, 8'hA0, -1, -1, 1'b0, 1'b0);
    vsync_pulse();
    chk("b_nominal_writes", 32'(nwe[1]), 32'd8);
    chk("b_nominal_frame_cnt", 32'(fc_b), 32'd1);
    chk("b_nominal_done", 32'(ndone[1]), 32'd1);
    chk("b_nominal_line_err", 32'(le_b), 32'd0);
    for (int f = 1; f < 256; f++) begin
      line_t(1, 4, 8'h90, 8'h90, -1, -1, 1'b0, 1'b0);
      line_t(1, 4, 8'h70, 8'h70, -1, -1, f == 100, 1'b0);
      vsync_pulse();
    end
    chk("b_wrap_frame_cnt", 32'(fc_b), 32'd0);
    chk("b_wrap_done", 32'(ndone[1]), 32'd256);
    chk("b_wrap_writes", 32'(nwe[1]), 32'd2048);
    chk("b_wrap_line_err", 32'(le_b), 32'd0);
    repeat (3) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Camera capture stage directly upstream of the VGA frame-buffer block.
- Runs in the PCLK domain of an OV7670 configured for YUV422 output (byte order Y0 U0 Y1 V0).
- Extracts the 4-bit luma (Y[7:4]) of each pixel and produces the frame-buffer write port: we, addra, vga_o.
- Also flags frame completion, counts frames and reports geometry errors.

Parameters:
- H_ACTIVE, 640: pixels per line written to the buffer.
- V_ACTIVE, 480: lines per frame written to the buffer.
- AW, 20: write address width.

Ports:
- PCLK  in  1  camera pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cap_en  in  1  capture enable.
- VSYNC  in  1  camera vertical sync, active high during frame blanking.
- HREF  in  1  camera line-valid.
- D  in  8  camera data byte.
- we  out  1  frame-buffer write enable.
- addra  out  AW  frame-buffer write address.
- vga_o  out  4  frame-buffer write data (luma).
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- frame_cnt  out  8  count of completed frames; wraps.
- line_err  out  1  sticky flag: a line had a pixel count other than H_ACTIVE, or a frame had a line count other than V_ACTIVE.

Behaviour:
- **Clock and reset.** All logic on posedge PCLK. reset is sampled synchronously.
- **Reset values.** we=0, addra=0, vga_o=0, frame_done=0, frame_cnt=0, line_err=0. Internal state: state=S_IDLE, byte_ph=0, col=0, line=0, line_base=0.
- **Input stage.** VSYNC, HREF and D are registered once into vs_q, hr_q, d_q. The FSM uses only the registered copies. vs_q_d holds the previous vs_q for edge detection.
- **Latency.** A Y byte present on D at edge N appears as we=1 with vga_o=D[7:4] after edge N+2.
- **S_IDLE.**
  - cap_en=1 → go to S_WAIT.
  - Otherwise outputs stay idle: we=0.
- **S_WAIT (waiting for frame start).**
  - A falling edge of vs_q (vs_q_d=1, vs_q=0) → go to S_FRAME; clear col, line, line_base and byte_ph.
  - cap_en=0 → go to S_IDLE.
  - A capture never starts mid-frame.
- **S_FRAME, with hr_q=1.**
  - byte_ph toggles every cycle.
  - When byte_ph=0 (Y byte) and col<H_ACTIVE and line<V_ACTIVE: register we=1, addra=line_base+col, vga_o=d_q[7:4].
  - When byte_ph=0, col increments, saturating at H_ACTIVE+1.
  - Chroma bytes (byte_ph=1) are never written.
- **S_FRAME, line end.**
  - Line end is a falling edge of hr_q.
  - byte_ph←0, col←0, line←line+1 (saturating at V_ACTIVE+1), line_base←line_base+H_ACTIVE.
  - If col≠H_ACTIVE at line end, set line_err.
- **S_FRAME, frame end.**
  - Frame end is a rising edge of vs_q.
  - If line≠V_ACTIVE, set line_err.
  - Go to S_DONE.
- **S_DONE.** One cycle only:
  - frame_done=1 and frame_cnt←frame_cnt+1; 255 wraps to 0.
  - Next state is S_WAIT if cap_en=1, else S_IDLE.
- **we outside writes.** we=0 on every cycle not meeting the write condition. addra and vga_o hold their last values when we=0.
- **Address range.** The highest address written is H_ACTIVE*V_ACTIVE−1 = 307199. addra[19] is always 0 at defaults.
- **Out-of-range pixels.** Pixels beyond H_ACTIVE columns or V_ACTIVE lines are dropped without write; there is no address wrap.
- **cap_en deasserted mid-frame.** The current frame completes normally, including the frame_done pulse. cap_en is consulted only in S_IDLE, S_WAIT and S_DONE.
- **Simultaneous events.** If a vs_q rise coincides with an hr_q fall, line-end bookkeeping occurs in the same cycle as the frame-end transition. The line_err check uses the already-incremented line count.
- **Reset mid-frame.** All registers return to reset values on the next edge, so we drops to 0 immediately. A new capture waits for the next VSYNC falling edge.
- **line_err.** Cleared only by reset.

Test Plan:
- **Nominal frame.** reset 4 cycles, cap_en=1; one frame of 480 lines × 1280 bytes with Y bytes=8'hA0|col[3:0]; VSYNC pulse before and after.
  - Expect exactly 307200 writes, addresses 0..307199 in order, vga_o=4'hA.
  - Expect frame_done for one cycle, frame_cnt=1, line_err=0.
- **Latency and chroma.** Single line; Y byte 8'hF3 at edge N, U byte 8'h5C at N+1.
  - Expect we=1, vga_o=4'hF after edge N+2.
  - Expect no write for the U byte.
- **Long line.** One line of 1300 bytes (650 pixels).
  - Expect only 640 writes for that line.
  - Expect line_err=1 at line end; next line base address=640.
- **Start mid-frame.** cap_en raised while VSYNC=0 and HREF is active.
  - Expect no writes until after the next VSYNC high→low.
  - The following frame captures normally starting at addra=0.
- **Reset mid-frame.** Assert reset at line 100, col 37.
  - Expect we=0 and addra=0 after the next edge, frame_cnt=0.
  - The next frame captures from address 0.
- **Counter wrap.** 256 short frames (V_ACTIVE=2, H_ACTIVE=4 override).
  - Expect frame_cnt wraps to 0.
  - Expect 256 frame_done pulses, line_err=0.
